// File: rtl/uci_move_parser.sv
// UCI long-algebraic move parser: turns a byte stream such as "e7e8q\n" into a
// move_t with a one-cycle valid pulse, or a one-cycle error pulse per bad token.
package uci_pkg;
   typedef enum logic [2:0] {
      SPECIAL_UNKNOWN        = 3'd0,
      SPECIAL_PROMOTE_KNIGHT = 3'd1,
      SPECIAL_PROMOTE_BISHOP = 3'd2,
      SPECIAL_PROMOTE_ROOK   = 3'd3,
      SPECIAL_PROMOTE_QUEEN  = 3'd4
   } special_t;

   typedef struct packed {
      logic [5:0] src;
      logic [5:0] dst;
      special_t   special;
   } move_t;
endpackage

module uci_move_parser
   import uci_pkg::*;
#(
   parameter int MAX_TOKEN_LEN = 8
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output move_t      move_out,
   output logic       valid_out,
   output logic       error_out,
   output logic       busy_out
);
   localparam int CW = $clog2(MAX_TOKEN_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_TOKEN_LEN);

   typedef enum logic [2:0] {
      IDLE, SRC_RNK, DST_FIL, DST_RNK, PROMO_OR_END, END, DISCARD
   } state_t;

   state_t        state, state_next;
   logic [2:0]    src_fil, src_fil_next, src_rnk, src_rnk_next;
   logic [2:0]    dst_fil, dst_fil_next, dst_rnk, dst_rnk_next;
   special_t      special, special_next;
   logic [CW-1:0] count, count_next;
   move_t         move_next;
   logic          valid_next, error_next;

   logic          is_term, is_fil, is_rnk, is_promo;
   logic [7:0]    fil_off, rnk_off;
   special_t      promo_kind;
   logic          commit;
   special_t      commit_special;

   assign is_term = (byte_in == 8'h20) || (byte_in == 8'h0D) || (byte_in == 8'h0A);
   assign is_fil  = (byte_in >= 8'h61) && (byte_in <= 8'h68);
   assign is_rnk  = (byte_in >= 8'h31) && (byte_in <= 8'h38);
   assign fil_off = byte_in - 8'h61;
   assign rnk_off = byte_in - 8'h31;

   always_comb begin
      is_promo   = 1'b1;
      promo_kind = SPECIAL_UNKNOWN;
      case (byte_in)
         8'h6E:   promo_kind = SPECIAL_PROMOTE_KNIGHT;
         8'h62:   promo_kind = SPECIAL_PROMOTE_BISHOP;
         8'h72:   promo_kind = SPECIAL_PROMOTE_ROOK;
         8'h71:   promo_kind = SPECIAL_PROMOTE_QUEEN;
         default: is_promo = 1'b0;
      endcase
   end

   always_comb begin
      state_next     = state;
      src_fil_next   = src_fil;
      src_rnk_next   = src_rnk;
      dst_fil_next   = dst_fil;
      dst_rnk_next   = dst_rnk;
      special_next   = special;
      count_next     = count;
      move_next      = move_out;
      valid_next     = 1'b0;
      error_next     = 1'b0;
      commit         = 1'b0;
      commit_special = SPECIAL_UNKNOWN;

      if (byte_valid_in) begin
         // A terminator arriving mid-coordinate ends the token immediately so
         // that every bad token yields exactly one error pulse.
         case (state)
            IDLE: begin
               if (is_fil) begin
                  src_fil_next = fil_off[2:0];
                  special_next = SPECIAL_UNKNOWN;
                  state_next   = SRC_RNK;
               end else if (!is_term) begin
                  state_next = DISCARD;
               end
            end
            SRC_RNK: begin
               if (is_rnk) begin
                  src_rnk_next = rnk_off[2:0];
                  state_next   = DST_FIL;
               end else if (is_term) begin
                  error_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = DISCARD;
               end
            end
            DST_FIL: begin
               if (is_fil) begin
                  dst_fil_next = fil_off[2:0];
                  state_next   = DST_RNK;
               end else if (is_term) begin
                  error_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = DISCARD;
               end
            end
            DST_RNK: begin
               if (is_rnk) begin
                  dst_rnk_next = rnk_off[2:0];
                  state_next   = PROMO_OR_END;
               end else if (is_term) begin
                  error_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = DISCARD;
               end
            end
            PROMO_OR_END: begin
               if (is_term) begin
                  commit         = 1'b1;
                  commit_special = SPECIAL_UNKNOWN;
               end else if (is_promo) begin
                  special_next = promo_kind;
                  state_next   = END;
               end else begin
                  state_next = DISCARD;
               end
            end
            END: begin
               if (is_term) begin
                  commit         = 1'b1;
                  commit_special = special;
               end else begin
                  state_next = DISCARD;
               end
            end
            DISCARD: begin
               if (is_term) begin
                  error_next = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase

         if (commit) begin
            state_next = IDLE;
            if ({src_rnk, src_fil} == {dst_rnk, dst_fil}) begin
               error_next = 1'b1;
            end else begin
               valid_next        = 1'b1;
               move_next.src     = {src_rnk, src_fil};
               move_next.dst     = {dst_rnk, dst_fil};
               move_next.special = commit_special;
            end
         end

         if (state == IDLE || state_next == IDLE) begin
            count_next = '0;
         end else if (!is_term && count != CNT_MAX) begin
            count_next = count + 1'b1;
         end
         if (state_next != IDLE && count_next == CNT_MAX) begin
            state_next = DISCARD;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= IDLE;
         src_fil   <= '0;
         src_rnk   <= '0;
         dst_fil   <= '0;
         dst_rnk   <= '0;
         special   <= SPECIAL_UNKNOWN;
         count     <= '0;
         move_out  <= '{src: 6'd0, dst: 6'd0, special: SPECIAL_UNKNOWN};
         valid_out <= 1'b0;
         error_out <= 1'b0;
         busy_out  <= 1'b0;
      end else begin
         state     <= state_next;
         src_fil   <= src_fil_next;
         src_rnk   <= src_rnk_next;
         dst_fil   <= dst_fil_next;
         dst_rnk   <= dst_rnk_next;
         special   <= special_next;
         count     <= count_next;
         move_out  <= move_next;
         valid_out <= valid_next;
         error_out <= error_next;
         busy_out  <= (state_next != IDLE);
      end
   end
endmodule

// File: tb/tb_uci_move_parser.sv
// Bench for uci_move_parser: token-level reference model feeding a scoreboard,
// with an independent monitor that checks every valid/error pulse.
module tb_uci_move_parser;
   import uci_pkg::*;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid_in = 1'b0;
   move_t      move_out;
   logic       valid_out, error_out, busy_out;

   uci_move_parser #(.MAX_TOKEN_LEN(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .move_out(move_out), .valid_out(valid_out), .error_out(error_out), .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit    is_valid;
      move_t mv;
      int    due;
   } exp_t;

   exp_t        sbq[$];
   byte unsigned tok[$];
   move_t       last_good;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   initial forever begin
      @(posedge clk_in);
      cyc++;
   end

   function automatic move_t mk(int src, int dst, special_t sp);
      move_t m;
      m.src = 6'(src);
      m.dst = 6'(dst);
      m.special = sp;
      return m;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic bit is_term(byte unsigned b);
      return b == 8'h20 || b == 8'h0D || b == 8'h0A;
   endfunction

   // A token is a legal move iff it is file,rank,file,rank[,promo] with distinct squares.
   function automatic bit eval_token(output move_t mv);
      int n = tok.size();
      int s, d;
      bit ok;
      special_t sp = SPECIAL_UNKNOWN;
      mv = mk(0, 0, SPECIAL_UNKNOWN);
      if (n != 4 && n != 5) return 0;
      ok = tok[0] inside {[8'h61:8'h68]} && tok[1] inside {[8'h31:8'h38]} &&
           tok[2] inside {[8'h61:8'h68]} && tok[3] inside {[8'h31:8'h38]};
      if (n == 5) begin
         case (tok[4])
            8'h6E:   sp = SPECIAL_PROMOTE_KNIGHT;
            8'h62:   sp = SPECIAL_PROMOTE_BISHOP;
            8'h72:   sp = SPECIAL_PROMOTE_ROOK;
            8'h71:   sp = SPECIAL_PROMOTE_QUEEN;
            default: ok = 0;
         endcase
      end
      if (!ok) return 0;
      s = (int'(tok[1]) - 8'h31) * 8 + (int'(tok[0]) - 8'h61);
      d = (int'(tok[3]) - 8'h31) * 8 + (int'(tok[2]) - 8'h61);
      if (s == d) return 0;
      mv = mk(s, d, sp);
      return 1;
   endfunction

   task automatic send_byte(input byte unsigned b);
      exp_t  e;
      move_t mv;
      bit    ok;
      byte_in = b;
      byte_valid_in = 1'b1;
      if (is_term(b)) begin
         if (tok.size() != 0) begin
            ok = eval_token(mv);
            if (ok) last_good = mv;
            e.is_valid = ok;
            e.mv = last_good;
            e.due = cyc + 1;
            sbq.push_back(e);
            tok.delete();
         end
      end else begin
         tok.push_back(b);
      end
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      check("busy", 32'(busy_out), 32'(tok.size() != 0));
   endtask

   task automatic idle(input int n);
      byte_valid_in = 1'b0;
      repeat (n) @(negedge clk_in);
   endtask

   task automatic send_str(input string s, input int maxgap);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         if (maxgap > 0) idle($urandom_range(maxgap, 0));
      end
   endtask

   // Monitor: every pulse must match the head of the scoreboard on its due cycle.
   initial forever begin
      exp_t e;
      @(negedge clk_in);
      if (rst_in) begin
         if (valid_out && error_out) begin
            checks++;
            errors++;
            $display("FAIL both_pulses: valid_out=1 error_out=1 at cycle %0d, required not both", cyc);
         end else if (valid_out || error_out) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: valid=%0b error=%0b at cycle %0d, required none",
                        valid_out, error_out, cyc);
            end else begin
               e = sbq.pop_front();
               check("pulse_kind_valid", 32'(valid_out), 32'(e.is_valid));
               check("pulse_cycle", 32'(cyc), 32'(e.due));
               check("move_out", 32'(move_out), 32'(e.mv));
            end
         end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: none by cycle %0d, required %s at cycle %0d",
                     cyc, e.is_valid ? "valid" : "error", e.due);
         end
      end
   end

   initial begin
      byte unsigned q[$];
      int kind, n;
      last_good = mk(0, 0, SPECIAL_UNKNOWN);
      repeat (3) @(negedge clk_in);
      check("reset_move", 32'(move_out), 32'(0));
      check("reset_valid", 32'(valid_out), 32'(0));
      check("reset_error", 32'(error_out), 32'(0));
      check("reset_busy", 32'(busy_out), 32'(0));
      rst_in = 1'b1;
      @(negedge clk_in);

      send_str("e2e4\n", 0);
      idle(2);
      check("e2e4_move", 32'(move_out), 32'(mk(12, 28, SPECIAL_UNKNOWN)));
      send_str("e7e8q\r\n", 0);
      idle(2);
      check("e7e8q_move", 32'(move_out), 32'(mk(52, 60, SPECIAL_PROMOTE_QUEEN)));
      send_str("e1g1 e8g8\n", 0);
      idle(2);
      check("e8g8_move", 32'(move_out), 32'(mk(60, 62, SPECIAL_UNKNOWN)));
      send_str("e2x4\ne2e\ne2e2\ne7e8k\n", 0);
      idle(2);
      check("hold_after_errors", 32'(move_out), 32'(mk(60, 62, SPECIAL_UNKNOWN)));
      send_str("  \r\n z9\nabcdefghijklmn\ne2e4qq\n", 1);
      idle(3);

      // Reset in the middle of a token.
      send_str("e2e", 0);
      rst_in = 1'b0;
      tok.delete();
      last_good = mk(0, 0, SPECIAL_UNKNOWN);
      #1;
      check("async_reset_move", 32'(move_out), 32'(0));
      @(negedge clk_in);
      check("reset_mid_busy", 32'(busy_out), 32'(0));
      check("reset_mid_pulses", 32'({valid_out, error_out}), 32'(0));
      rst_in = 1'b1;
      @(negedge clk_in);
      check("post_reset_move", 32'(move_out), 32'(0));
      send_str("d2d4\n", 0);
      idle(2);
      check("d2d4_move", 32'(move_out), 32'(mk(11, 27, SPECIAL_UNKNOWN)));
      send_str("a7a8n\n", 3);
      idle(2);
      check("a7a8n_move", 32'(move_out), 32'(mk(48, 56, SPECIAL_PROMOTE_KNIGHT)));

      // Random tokens: legal moves, promotions, null moves and junk.
      for (int t = 0; t < 300; t++) begin
         q.delete();
         kind = $urandom_range(9, 0);
         if (kind <= 5) begin
            q.push_back(8'(8'h61 + $urandom_range(7, 0)));
            q.push_back(8'(8'h31 + $urandom_range(7, 0)));
            q.push_back(8'(8'h61 + $urandom_range(7, 0)));
            q.push_back(8'(8'h31 + $urandom_range(7, 0)));
            if (kind >= 3) begin
               case ($urandom_range(4, 0))
                  0: q.push_back(8'h6E);
                  1: q.push_back(8'h62);
                  2: q.push_back(8'h72);
                  3: q.push_back(8'h71);
                  default: q.push_back(8'h6B);
               endcase
            end
         end else if (kind == 6) begin
            q.push_back(8'h63); q.push_back(8'h33); q.push_back(8'h63); q.push_back(8'h33);
         end else begin
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) begin
               case ($urandom_range(3, 0))
                  0: q.push_back(8'(8'h61 + $urandom_range(7, 0)));
                  1: q.push_back(8'(8'h31 + $urandom_range(8, 0)));
                  2: q.push_back(8'h71);
                  default: q.push_back(8'(8'h69 + $urandom_range(15, 0)));
               endcase
            end
         end
         case ($urandom_range(2, 0))
            0: q.push_back(8'h20);
            1: q.push_back(8'h0D);
            default: q.push_back(8'h0A);
         endcase
         if ($urandom_range(3, 0) == 0) q.push_back(8'h0A);
         n = ($urandom_range(1, 0) == 0) ? 0 : 3;
         foreach (q[i]) begin
            send_byte(q[i]);
            if (n > 0) idle($urandom_range(n, 0));
         end
      end

      idle(5);
      check("scoreboard_empty", 32'(sbq.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
